// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// Holds operands stable for an opcode-dependent number of cycles, then returns the result.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int DIV_LAT = 4,
    parameter int MUL_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A_VALID,
    output logic             A_READY,
    input  logic [WIDTH-1:0] A_OP1,
    input  logic [WIDTH-1:0] A_OP2,
    input  logic [2:0]       A_OP,
    output logic             A_RVALID,
    input  logic             A_RREADY,
    input  logic             B_VALID,
    output logic             B_READY,
    input  logic [WIDTH-1:0] B_OP1,
    input  logic [WIDTH-1:0] B_OP2,
    input  logic [2:0]       B_OP,
    output logic             B_RVALID,
    input  logic             B_RREADY,
    output logic [WIDTH-1:0] RES,
    output logic             RZF,
    output logic             RERR,
    output logic [WIDTH-1:0] ALU_OP1,
    output logic [WIDTH-1:0] ALU_OP2,
    output logic [2:0]       ALU_OP,
    input  logic [WIDTH-1:0] ALU_OPS,
    input  logic             ALU_ZF
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b111;
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;      // 1 = requester B
    logic             last_b_q, last_b_d;    // last-served pointer, 1 = B
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             rzf_q, rzf_d;
    logic             rerr_q, rerr_d;

    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;
    logic [2:0]       sel_op;
    logic             owner_rready;

    // On a tie the requester that was not served last wins.
    assign grant_a = A_VALID && (!B_VALID || last_b_q);
    assign grant_b = B_VALID && !grant_a;

    assign A_READY = (state_q == IDLE) && grant_a;
    assign B_READY = (state_q == IDLE) && grant_b;

    assign sel_op1      = grant_b ? B_OP1 : A_OP1;
    assign sel_op2      = grant_b ? B_OP2 : A_OP2;
    assign sel_op       = grant_b ? B_OP  : A_OP;
    assign owner_rready = owner_q ? B_RREADY : A_RREADY;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op_d     = op_q;
        res_d    = res_q;
        rzf_d    = rzf_q;
        rerr_d   = rerr_q;
        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    owner_d  = grant_b;
                    last_b_d = grant_b;
                    op1_d    = sel_op1;
                    op2_d    = sel_op2;
                    op_d     = sel_op;
                    if (sel_op == OP_DIV)      cnt_d = DIV_CNT;
                    else if (sel_op == OP_MUL) cnt_d = MUL_CNT;
                    else                       cnt_d = 4'd0;
                    // Divide by zero never reaches the ALU; answer immediately.
                    if (sel_op == OP_DIV && sel_op2 == '0) begin
                        res_d   = '0;
                        rzf_d   = 1'b1;
                        rerr_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = ALU_OPS;
                    rzf_d   = ALU_ZF;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (owner_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_b_q <= 1'b1;
            cnt_q    <= 4'd0;
            op1_q    <= '0;
            op2_q    <= '0;
            op_q     <= 3'd0;
            res_q    <= '0;
            rzf_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op_q     <= op_d;
            res_q    <= res_d;
            rzf_q    <= rzf_d;
            rerr_q   <= rerr_d;
        end
    end

    assign A_RVALID = (state_q == RESP) && !owner_q;
    assign B_RVALID = (state_q == RESP) && owner_q;
    assign RES      = res_q;
    assign RZF      = rzf_q;
    assign RERR     = rerr_q;
    assign ALU_OP1  = op1_q;
    assign ALU_OP2  = op2_q;
    assign ALU_OP   = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model plus per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;

    localparam int W       = 32;
    localparam int DIV_LAT = 4;
    localparam int MUL_LAT = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          A_VALID = 1'b0, B_VALID = 1'b0;
    logic          A_READY, B_READY;
    logic [W-1:0]  A_OP1 = '0, A_OP2 = '0, B_OP1 = '0, B_OP2 = '0;
    logic [2:0]    A_OP = 3'd0, B_OP = 3'd0;
    logic          A_RVALID, B_RVALID;
    logic          A_RREADY = 1'b1, B_RREADY = 1'b1;
    logic [W-1:0]  RES;
    logic          RZF, RERR;
    logic [W-1:0]  ALU_OP1, ALU_OP2;
    logic [2:0]    ALU_OP;
    logic [W-1:0]  ALU_OPS;
    logic          ALU_ZF;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.WIDTH(W), .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_OP1(A_OP1), .A_OP2(A_OP2), .A_OP(A_OP),
        .A_RVALID(A_RVALID), .A_RREADY(A_RREADY),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_OP1(B_OP1), .B_OP2(B_OP2), .B_OP(B_OP),
        .B_RVALID(B_RVALID), .B_RREADY(B_RREADY),
        .RES(RES), .RZF(RZF), .RERR(RERR),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OP(ALU_OP),
        .ALU_OPS(ALU_OPS), .ALU_ZF(ALU_ZF)
    );

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5:    return (b == 0) ? 32'hDEADBEEF : a / b;
            3'd6:    return '0;
            default: return a * b;
        endcase
    endfunction

    // Environment ALU (combinational, as in the real datapath)
    always_comb begin
        ALU_OPS = alu_f(ALU_OP, ALU_OP1, ALU_OP2);
        ALU_ZF  = (ALU_OPS == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic          m_busy   = 1'b0;
    logic          m_owner  = 1'b0;
    logic          m_last_b = 1'b1;
    int            m_wait   = 0;     // cycles left before the response is presented
    logic [W-1:0]  m_res    = '0;
    logic          m_zf     = 1'b0;
    logic          m_err    = 1'b0;
    logic [W-1:0]  m_alu1   = '0, m_alu2 = '0;
    logic [2:0]    m_aluop  = 3'd0;

    function automatic logic exp_grant_b();
        if (A_VALID && B_VALID) return !m_last_b;
        return B_VALID;
    endfunction

    function automatic int op_lat(input logic [2:0] op);
        if (op == 3'b101) return DIV_LAT;
        if (op == 3'b111) return MUL_LAT;
        return 0;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy   <= 1'b0;
            m_last_b <= 1'b1;
            m_wait   <= 0;
            m_res    <= '0;
            m_zf     <= 1'b0;
            m_err    <= 1'b0;
            m_alu1   <= '0;
            m_alu2   <= '0;
            m_aluop  <= 3'd0;
        end else if (!m_busy) begin
            if (A_VALID || B_VALID) begin
                logic          gb;
                logic [W-1:0]  x, y;
                logic [2:0]    o;
                gb = exp_grant_b();
                x  = gb ? B_OP1 : A_OP1;
                y  = gb ? B_OP2 : A_OP2;
                o  = gb ? B_OP  : A_OP;
                m_busy   <= 1'b1;
                m_owner  <= gb;
                m_last_b <= gb;
                m_alu1   <= x;
                m_alu2   <= y;
                m_aluop  <= o;
                if (o == 3'b101 && y == '0) begin
                    m_res  <= '0;
                    m_zf   <= 1'b1;
                    m_err  <= 1'b1;
                    m_wait <= 0;
                end else begin
                    m_res  <= alu_f(o, x, y);
                    m_zf   <= (alu_f(o, x, y) == '0);
                    m_err  <= 1'b0;
                    m_wait <= 1 + op_lat(o);
                end
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (m_owner ? B_RREADY : A_RREADY) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        logic resp, gb;
        resp = m_busy && (m_wait == 0);
        gb   = exp_grant_b();
        check("a_ready",  A_READY,  !m_busy && A_VALID && !gb);
        check("b_ready",  B_READY,  !m_busy && gb);
        check("a_rvalid", A_RVALID, resp && !m_owner);
        check("b_rvalid", B_RVALID, resp && m_owner);
        check("alu_op1",  ALU_OP1,  m_alu1);
        check("alu_op2",  ALU_OP2,  m_alu2);
        check("alu_op",   ALU_OP,   m_aluop);
        if (resp) begin
            check("res",  RES,  m_res);
            check("rzf",  RZF,  m_zf);
            check("rerr", RERR, m_err);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic who, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic seen;
        seen = 1'b0;
        if (who) begin B_OP = op; B_OP1 = x; B_OP2 = y; B_VALID = 1'b1; end
        else     begin A_OP = op; A_OP1 = x; A_OP2 = y; A_VALID = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (who ? B_READY : A_READY) begin seen = 1'b1; break; end
        end
        check(who ? "accept_b" : "accept_a", seen, 1'b1);
        tick();
        if (who) B_VALID = 1'b0; else A_VALID = 1'b0;
    endtask

    // Called just after the accept edge; lat counts edges until RVALID is visible.
    task automatic wait_resp(input logic who, input logic [W-1:0] res, input logic zf, input logic err,
                             input int lat, input string name);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (who ? B_RVALID : A_RVALID) begin seen = 1'b1; break; end
            n++;
        end
        check({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            check({name, "_res"},   RES,  res);
            check({name, "_rzf"},   RZF,  zf);
            check({name, "_rerr"},  RERR, err);
            check({name, "_lat"},   n,    lat);
            check({name, "_other"}, who ? A_RVALID : B_RVALID, 1'b0);
        end
    endtask

    initial begin
        repeat (2) tick();
        @(negedge CLK);
        check("rst_res", RES, 0);
        check("rst_rvalid", {A_RVALID, B_RVALID}, 2'b00);
        tick();
        RST_N = 1'b1;
        tick();

        // Simple ADD from A
        send(1'b0, 3'b010, 32'd5, 32'd7);
        wait_resp(1'b0, 32'd12, 1'b0, 1'b0, 1, "add");
        tick();

        // B DIV 100/7 : held for DIV_LAT+1 EXEC cycles
        send(1'b1, 3'b101, 32'd100, 32'd7);
        wait_resp(1'b1, 32'd14, 1'b0, 1'b0, 1 + DIV_LAT, "div");
        tick();

        // Both requesting: order must alternate A, B, A, B
        A_OP = 3'b011; A_OP1 = 32'd9;    A_OP2 = 32'd9;
        B_OP = 3'b000; B_OP1 = 32'hF0;   B_OP2 = 32'h0F;
        A_VALID = 1'b1; B_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge CLK);
                if (A_READY || B_READY) begin seen = 1'b1; break; end
            end
            check("tie_seen", seen, 1'b1);
            check("tie_order_b", B_READY, (k % 2) == 1);
            check("tie_order_a", A_READY, (k % 2) == 0);
            tick();
            if (k == 3) begin A_VALID = 1'b0; B_VALID = 1'b0; end
            wait_resp((k % 2) == 1, 32'd0, 1'b1, 1'b0, 1, "tie");
            tick();
        end

        // MUL 6*7
        send(1'b0, 3'b111, 32'd6, 32'd7);
        wait_resp(1'b0, 32'd42, 1'b0, 1'b0, 1 + MUL_LAT, "mul");
        tick();

        // Divide by zero skips EXEC
        send(1'b0, 3'b101, 32'd8, 32'd0);
        wait_resp(1'b0, 32'd0, 1'b1, 1'b1, 0, "div0");
        tick();

        // Response backpressure on A while B waits
        A_RREADY = 1'b0;
        send(1'b0, 3'b010, 32'd1, 32'd2);
        B_OP = 3'b001; B_OP1 = 32'd3; B_OP2 = 32'd4; B_VALID = 1'b1;
        wait_resp(1'b0, 32'd3, 1'b0, 1'b0, 1, "bp");
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("bp_b_ready", B_READY, 1'b0);
            check("bp_a_rvalid", A_RVALID, 1'b1);
            check("bp_res_hold", RES, 32'd3);
        end
        tick();
        A_RREADY = 1'b1;
        @(negedge CLK);
        check("bp_b_ready_resp", B_READY, 1'b0);
        tick();
        @(negedge CLK);
        check("bp_b_ready_idle", B_READY, 1'b1);
        tick();
        B_VALID = 1'b0;
        wait_resp(1'b1, 32'd7, 1'b0, 1'b0, 1, "bp_b");
        tick();

        // Reset in the middle of a MUL
        send(1'b0, 3'b111, 32'd6, 32'd7);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("mrst_rvalid", {A_RVALID, B_RVALID}, 2'b00);
        check("mrst_res", RES, 0);
        check("mrst_flags", {RZF, RERR}, 2'b00);
        check("mrst_alu1", ALU_OP1, 0);
        check("mrst_alu2", ALU_OP2, 0);
        check("mrst_aluop", ALU_OP, 0);
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("mrst_no_rvalid", {A_RVALID, B_RVALID}, 2'b00);
        end
        tick();
        send(1'b0, 3'b010, 32'd20, 32'd22);
        wait_resp(1'b0, 32'd42, 1'b0, 1'b0, 1, "post_rst");
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            A_VALID  = 1'($urandom_range(0, 1));
            B_VALID  = 1'($urandom_range(0, 1));
            A_OP     = 3'($urandom_range(0, 7));
            B_OP     = 3'($urandom_range(0, 7));
            A_OP1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
            B_OP1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
            A_OP2    = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 300));
            B_OP2    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            A_RREADY = ($urandom_range(0, 3) != 0);
            B_RREADY = ($urandom_range(0, 3) != 0);
        end
        A_VALID = 1'b0; B_VALID = 1'b0;
        A_RREADY = 1'b1; B_RREADY = 1'b1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter for the shared 3-bit-opcode ALU (AND, OR, ADD, SUB, SLT, DIV, ZERO, MUL). It accepts operation requests from two requesters (A, B) over valid/ready handshakes and grants them round-robin. It registers the operands, drives the ALU, and holds them stable for an opcode-dependent number of cycles so multi-cycle DIV/MUL paths can settle. It then returns the result with the zero flag through a response handshake. It sits between the datapath control units and the single combinational ALU instance.

## Interface
- WIDTH, 32, operand/result width
- DIV_LAT, 4, extra EXEC cycles for opcode 3'b101 (legal 0..15)
- MUL_LAT, 2, extra EXEC cycles for opcode 3'b111 (legal 0..15)

- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- A_VALID  in  1  requester A has a request
- A_READY  out  1  request A accepted this cycle
- A_OP1, A_OP2  in  WIDTH  requester A operands
- A_OP  in  3  requester A opcode
- A_RVALID  out  1  response for A valid
- A_RREADY  in  1  A consumes response
- B_VALID, B_READY, B_OP1, B_OP2, B_OP, B_RVALID, B_RREADY  same as A, for requester B
- RES  out  WIDTH  result, shared, qualified by A_RVALID/B_RVALID
- RZF  out  1  zero flag of RES
- RERR  out  1  divide-by-zero error
- ALU_OP1, ALU_OP2  out  WIDTH  operands to ALU
- ALU_OP  out  3  opcode to ALU
- ALU_OPS  in  WIDTH  ALU result
- ALU_ZF  in  1  ALU zero flag

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant logic is combinational. If only one VALID is high, that requester is granted. If both are high, the requester other than the last-served one is granted. The last-served pointer resets to B, so A wins the first tie. READY of the granted requester is high only in IDLE.
- Accept (VALID&READY at an edge): capture OP1, OP2, OP and owner; update the last-served pointer.
  - Counter load: DIV_LAT for 101, MUL_LAT for 111, 0 otherwise.
  - Next state is EXEC.
- Divide by zero (OP=101, OP2=0) at accept: skip EXEC and go directly to RESP with RES=0, RZF=1, RERR=1.
- EXEC: ALU_OP1/ALU_OP2/ALU_OP are held from the captured registers. The counter decrements each cycle. In the cycle where the counter is 0, ALU_OPS→RES and ALU_ZF→RZF are captured at the edge, RERR=0, and next state is RESP.
- RESP: the owner's RVALID=1 and the other requester's RVALID=0. RES/RZF/RERR are held. Transition to IDLE on the owner's RREADY=1. No new request is accepted in RESP.
- A requester dropping VALID before acceptance has no effect. Operands are sampled only at the accept edge.
- Widths: the block does no arithmetic on data. RES is exactly ALU_OPS. The counter is 4 bits.

## Timing
- Reset (RST_N low, any state, immediate): state IDLE, pointer B, A_RVALID=B_RVALID=0, RES=0, RZF=0, RERR=0, ALU_OP1=ALU_OP2=0, ALU_OP=0. A_READY/B_READY follow IDLE grant logic once RST_N is high. Any in-flight operation is discarded.
- Latency, accept edge to RVALID: 1+lat cycles, where lat is 0 for simple ops, DIV_LAT for DIV, and MUL_LAT for MUL. Divide by zero takes 1 cycle.
- ALU inputs change only at the accept edge and stay stable through EXEC and RESP.
- Response consumed at edge T: IDLE in cycle T+1, so the earliest next accept is edge T+1. Throughput is one operation per lat+3 cycles with RREADY held high.
- If RREADY is high in the first RESP cycle, RVALID is high for exactly one cycle.
- A request and its own response cannot overlap. READY is 0 outside IDLE.

## Test plan
- Reset, then A: OP=010, 5 + 7 with A_RREADY=1 -> A_READY high at accept, A_RVALID one cycle later, RES=12, RZF=0, RERR=0, B_RVALID=0.
- A and B both VALID: A SUB 9-9, B AND 0xF0&0x0F, repeated twice -> grant order A, B, A, B. Responses A: RES=0, RZF=1; B: RES=0, RZF=1. Each RVALID goes only to its owner.
- B DIV 100/7 with DIV_LAT=4 -> ALU inputs stable for 5 EXEC cycles, B_RVALID 5 cycles after accept, RES=14. MUL 6*7 with MUL_LAT=2 -> RES=42 after 3 cycles.
- A DIV 8/0 -> next cycle A_RVALID=1, RES=0, RZF=1, RERR=1, ALU_OPS ignored.
- Response backpressure: A_RREADY=0 for 4 cycles while B_VALID=1 -> A_RVALID and RES held, B_READY=0 throughout. B is accepted the cycle after A_RREADY rises.
- Assert RST_N low mid-EXEC of a MUL -> all outputs at reset values immediately. After release no RVALID appears, and a new A request completes normally.
